// File: rtl/hart_run_controller_pkg.sv
// Shared types for the hart run controller and the board display wrapper.
package hart_ctl_pkg;

    typedef enum logic [1:0] {
        HALTED  = 2'd0,
        STEP    = 2'd1,
        RUNNING = 2'd2,
        BREAK   = 2'd3
    } run_state_t;

    // HALTED and BREAK both hold the hart stopped
    function automatic logic is_stopped(input run_state_t s);
        return (s == HALTED) || (s == BREAK);
    endfunction

endpackage

// File: rtl/hart_run_controller_if.sv
// Board-side request / hart-side control bundle of the run controller.
interface hart_run_if
    import hart_ctl_pkg::*;
#(
    parameter int XLEN = 32
);
    logic            run_req;
    logic            step_req;
    logic            halt_req;
    logic            bp_enable;
    logic [XLEN-1:0] bp_addr;
    logic [XLEN-1:0] pc;
    logic            hart_en;
    run_state_t      state;
    logic            halted;
    logic [XLEN-1:0] retired;

    // board wrapper / hart side
    modport master (
        output run_req, step_req, halt_req, bp_enable, bp_addr, pc,
        input  hart_en, state, halted, retired
    );

    // controller side
    modport slave (
        input  run_req, step_req, halt_req, bp_enable, bp_addr, pc,
        output hart_en, state, halted, retired
    );
endinterface

// File: rtl/hart_run_controller_sync_edge_detect.sv
// Synchroniser plus rising-edge detector; emits a registered one-cycle pulse.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in,
    output logic pulse
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;

    // shift the raw level in, remember last synced level, register the edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            edge_q <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in};
            edge_q <= sync_q[SYNC_STAGES-1];
            pulse  <= sync_q[SYNC_STAGES-1] & ~edge_q;
        end
    end
endmodule

// File: rtl/hart_run_controller.sv
// Run/halt/step/breakpoint sequencer gating the hart's clock-enable.
module hart_run_controller
    import hart_ctl_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic      clk,
    input  logic      reset_n,
    hart_run_if.slave bus
);
    logic            run_p, step_p, halt_p;
    logic            bp_hit, hart_en, skip_bp;
    run_state_t      state_q, state_d;
    logic            halted_q;
    logic [XLEN-1:0] retired_q;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_run  (.clk(clk), .reset_n(reset_n), .in(bus.run_req),  .pulse(run_p));
    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_step (.clk(clk), .reset_n(reset_n), .in(bus.step_req), .pulse(step_p));
    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_halt (.clk(clk), .reset_n(reset_n), .in(bus.halt_req), .pulse(halt_p));

    // combinational PC compare so the breakpoint instruction never executes
    assign bp_hit  = bus.bp_enable && (bus.pc == bus.bp_addr) && !skip_bp;
    assign hart_en = (state_q == STEP) || ((state_q == RUNNING) && !bp_hit);

    // next state; halt beats step beats run
    always_comb begin
        state_d = state_q;
        case (state_q)
            HALTED:  if (halt_p)      state_d = HALTED;
                     else if (step_p) state_d = STEP;
                     else if (run_p)  state_d = RUNNING;
            STEP:                     state_d = HALTED;
            RUNNING: if (halt_p)      state_d = HALTED;
                     else if (bp_hit) state_d = BREAK;
            BREAK:   if (halt_p)      state_d = HALTED;
                     else if (step_p) state_d = STEP;
                     else if (run_p)  state_d = RUNNING;
            default:                  state_d = HALTED;
        endcase
    end

    // state, registered halted flag, breakpoint skip and retire counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= HALTED;
            halted_q  <= 1'b1;
            skip_bp   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q  <= state_d;
            halted_q <= is_stopped(state_d);
            // resuming from BREAK masks the compare until one instruction retires
            if ((state_q == BREAK) && (state_d == RUNNING))
                skip_bp <= 1'b1;
            else if ((state_q == RUNNING) && hart_en)
                skip_bp <= 1'b0;
            if (hart_en)
                retired_q <= retired_q + XLEN'(1);
        end
    end

    assign bus.hart_en = hart_en;
    assign bus.state   = state_q;
    assign bus.halted  = halted_q;
    assign bus.retired = retired_q;
endmodule

// File: tb/tb_hart_run_controller.sv
// Self-checking bench for hart_run_controller with a scoreboard of expected states.
module tb_hart_run_controller;
    import hart_ctl_pkg::*;

    logic clk;
    logic reset_n;
    logic pc_clr;
    int   n_tot, n_bad;
    run_state_t exp_q[$];

    hart_run_if #(.XLEN(32)) bif ();
    hart_run_if #(.XLEN(4))  bif2 ();

    hart_run_controller #(.XLEN(32), .SYNC_STAGES(2)) dut  (.clk(clk), .reset_n(reset_n), .bus(bif.slave));
    hart_run_controller #(.XLEN(4),  .SYNC_STAGES(2)) dut2 (.clk(clk), .reset_n(reset_n), .bus(bif2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // simple hart model: PC advances one instruction per enabled cycle
    always @(posedge clk) begin
        if (pc_clr)           bif.pc <= '0;
        else if (bif.hart_en) bif.pc <= bif.pc + 32'd4;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        pc_clr  = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
        pc_clr  = 1'b0;
    endtask

    // wait for the state to leave 'from', then pop and compare the expected state
    task automatic wait_change(input string tag, input run_state_t from);
        logic       seen;
        run_state_t e;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (bif.state != from) seen = 1'b1;
        end
        chk({tag, "_tmo"}, {31'd0, seen}, 32'd1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : from;
        chk(tag, {30'd0, bif.state}, {30'd0, e});
    endtask

    initial begin
        logic       seen;
        run_state_t e;
        n_tot = 0;
        n_bad = 0;
        reset_n = 1'b0;
        pc_clr  = 1'b1;
        bif.run_req = 0; bif.step_req = 0; bif.halt_req = 0;
        bif.bp_enable = 0; bif.bp_addr = '0;
        bif2.run_req = 0; bif2.step_req = 0; bif2.halt_req = 0;
        bif2.bp_enable = 0; bif2.bp_addr = '0; bif2.pc = '0;

        // reset values
        do_reset();
        chk("rst_state",  {30'd0, bif.state}, {30'd0, HALTED});
        chk("rst_halted", {31'd0, bif.halted}, 32'd1);
        chk("rst_en",     {31'd0, bif.hart_en}, 32'd0);
        chk("rst_ret",    bif.retired, 32'd0);

        // single step: request first sampled at edge k, hart_en high after k+3
        bif.step_req = 1'b1;
        exp_q.push_back(STEP);
        tick(); tick(); tick();
        chk("step_pre_en", {31'd0, bif.hart_en}, 32'd0);
        tick();
        e = exp_q.pop_front();
        chk("step_state", {30'd0, bif.state}, {30'd0, e});
        chk("step_en",    {31'd0, bif.hart_en}, 32'd1);
        tick();
        chk("step_back",  {30'd0, bif.state}, {30'd0, HALTED});
        chk("step_en0",   {31'd0, bif.hart_en}, 32'd0);
        chk("step_ret",   bif.retired, 32'd1);
        bif.step_req = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("step_once",  bif.retired, 32'd1);

        // breakpoint at 0x10 from a fresh reset
        do_reset();
        bif.bp_enable = 1'b1;
        bif.bp_addr   = 32'h10;
        bif.run_req   = 1'b1;
        exp_q.push_back(RUNNING);
        wait_change("bp_run", HALTED);
        bif.run_req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30 && bif.state != BREAK; i++) begin
            if (bif.state == RUNNING && bif.pc == 32'h10) begin
                chk("bp_en_hit", {31'd0, bif.hart_en}, 32'd0);
                seen = 1'b1;
            end
            tick();
        end
        chk("bp_seen",   {31'd0, seen}, 32'd1);
        chk("bp_state",  {30'd0, bif.state}, {30'd0, BREAK});
        chk("bp_ret",    bif.retired, 32'd4);
        chk("bp_pc",     bif.pc, 32'h10);
        chk("bp_halted", {31'd0, bif.halted}, 32'd1);
        for (int i = 0; i < 4; i++) tick();

        // resume past the breakpoint
        bif.run_req = 1'b1;
        exp_q.push_back(RUNNING);
        wait_change("res_run", BREAK);
        bif.run_req = 1'b0;
        chk("res_en", {31'd0, bif.hart_en}, 32'd1);
        chk("res_pc", bif.pc, 32'h10);
        tick();
        chk("res_pc2", bif.pc, 32'h14);
        chk("res_ret", bif.retired, 32'd5);
        // a step request while running is ignored
        bif.step_req = 1'b1;
        tick(); tick(); tick();
        bif.step_req = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("run_state", {30'd0, bif.state}, {30'd0, RUNNING});
        chk("run_ret",   bif.retired, 32'd15);

        // halt while running: HALTED after the third edge
        bif.halt_req = 1'b1;
        tick(); tick(); tick();
        chk("halt_pre", {30'd0, bif.state}, {30'd0, RUNNING});
        tick();
        chk("halt_state", {30'd0, bif.state}, {30'd0, HALTED});
        chk("halt_en",    {31'd0, bif.hart_en}, 32'd0);
        chk("halt_ret",   bif.retired, 32'd19);
        bif.halt_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("halt_hold", bif.retired, 32'd19);

        // coincident halt and run from HALTED stays halted
        bif.halt_req = 1'b1;
        bif.run_req  = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("prio_state", {30'd0, bif.state}, {30'd0, HALTED});
        chk("prio_en",    {31'd0, bif.hart_en}, 32'd0);
        chk("prio_ret",   bif.retired, 32'd19);
        bif.halt_req = 1'b0;
        bif.run_req  = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // asynchronous reset mid-run at retired=0x25
        bif.bp_enable = 1'b0;
        bif.run_req   = 1'b1;
        exp_q.push_back(RUNNING);
        wait_change("mr_run", HALTED);
        bif.run_req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (bif.retired == 32'h25) seen = 1'b1;
            else tick();
        end
        chk("mr_reach", {31'd0, seen}, 32'd1);
        bif.run_req = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        chk("mr_en",     {31'd0, bif.hart_en}, 32'd0);
        chk("mr_state",  {30'd0, bif.state}, {30'd0, HALTED});
        chk("mr_ret",    bif.retired, 32'd0);
        chk("mr_halted", {31'd0, bif.halted}, 32'd1);
        tick(); tick();
        reset_n = 1'b1;
        // run_req held through reset yields a pulse after release
        exp_q.push_back(RUNNING);
        wait_change("mr_held", HALTED);
        bif.run_req = 1'b0;

        // counter wrap on a 4-bit instance
        bif2.run_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (bif2.state == RUNNING) seen = 1'b1;
        end
        chk("wr_run", {31'd0, seen}, 32'd1);
        chk("wr_ret0", {28'd0, bif2.retired}, 32'd0);
        for (int i = 0; i < 15; i++) tick();
        chk("wr_max", {28'd0, bif2.retired}, 32'd15);
        tick();
        chk("wr_wrap", {28'd0, bif2.retired}, 32'd0);
        bif2.run_req = 1'b0;

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule

// File: doc/hart_run_controller.md
# hart_run_controller

- Sequences execution of the `hart` core for board-level debug: it gates the hart with a single clock-enable and supports halt, single-step, free-run and PC breakpoint modes.
- Requests come from push-buttons and switches; the block synchronises them and detects their edges.
- It exposes a retired-cycle counter for display on the HEX/LED peripherals.
- It sits between the board I/O wrapper and `hart`; `hart_en` drives the hart's clock-enable.

## Interface
Parameters:
- `XLEN`, 32: width of PC, breakpoint address and counter.
- `SYNC_STAGES`, 2: flip-flop stages in each request synchroniser; minimum 2.

Ports:
- `clk`  in  1: single clock; every register in the block is clocked by it.
- `reset_n`  in  1: asynchronous, active-low reset.
- `run_req`  in  1: raw level input; a rising edge requests free-run.
- `step_req`  in  1: raw level input; a rising edge requests a single step.
- `halt_req`  in  1: raw level input; a rising edge requests halt.
- `bp_enable`  in  1: enables breakpoint matching. Must be quasi-static; it is not synchronised.
- `bp_addr`  in  XLEN: breakpoint PC. Must be quasi-static.
- `pc`  in  XLEN: the hart's current PC, from `reg_state.pc`.
- `hart_en`  out  1: clock-enable to the hart; the hart executes one instruction per cycle while it is high.
- `state`  out  2: current controller state, of type `run_state_t`.
- `halted`  out  1: high in HALTED and BREAK.
- `retired`  out  XLEN: count of cycles in which `hart_en` was high.

## Operation
Request conditioning:
- Each `*_req` input passes through a `SYNC_STAGES`-deep synchroniser, followed by one register for rising-edge detection.
- The result is a one-cycle internal pulse: `run_p`, `step_p` or `halt_p`.

States:
- HALTED: `hart_en`=0.
  - `step_p` → STEP.
  - `run_p` → RUNNING.
- STEP: `hart_en`=1 for exactly one cycle, then → HALTED unconditionally. The breakpoint is ignored in this state.
- RUNNING: `hart_en`=1 unless there is a breakpoint hit.
  - Breakpoint hit means `bp_enable && pc==bp_addr && !skip_bp`.
  - On a hit, `hart_en` goes to 0 in the same cycle (combinational compare) and the state → BREAK.
  - `halt_p` → HALTED.
- BREAK: `hart_en`=0.
  - `run_p` → RUNNING with `skip_bp` set.
  - `step_p` → STEP.

`skip_bp`:
- A 1-bit register set on the BREAK→RUNNING transition.
- While it is set, the compare at the current `pc` is masked.
- It clears after the first cycle in RUNNING in which `hart_en`=1, so execution always progresses past the breakpoint.

Pulse priority when pulses coincide: `halt_p` > `step_p` > `run_p`.
- In HALTED, a simultaneous halt and run leaves the state in HALTED.
- `step_p` while RUNNING is ignored.
- `run_p` while RUNNING is ignored.
- A pulse arriving during STEP is ignored. It is not queued.

`retired`:
- Increments by 1 on every edge where `hart_en`=1.
- Wraps modulo 2^XLEN, so all-ones + 1 → 0.
- Never saturates.

Reset (asynchronous, any time, including mid-STEP or mid-RUN):
- State → HALTED.
- `hart_en`=0 immediately, since it is combinational from the reset state.
- `retired`=0, `skip_bp`=0.
- All synchroniser and edge registers → 0. A request input held high through reset therefore produces a pulse after reset release.

## Timing
- Reset values: `hart_en`=0, `state`=HALTED, `halted`=1, `retired`=0.
- Request latency: a raw input first sampled high at edge k produces its internal pulse in the cycle after edge k+SYNC_STAGES.
  - The state changes at edge k+SYNC_STAGES+1.
  - `hart_en` reflects the new state from that edge onward.
- Holding a request input high yields exactly one pulse. A new pulse needs a low period of at least 1 cycle after synchronisation.
- `hart_en` is a function of the state register, `pc`, `bp_*` and `skip_bp`. It is combinational only through the PC compare.
- `halted` and `state` are registered outputs.
- Breakpoint response has zero cycles of latency: the instruction at `bp_addr` is not executed until resume.

## Structure
- `hart_ctl_pkg` holds `typedef enum logic [1:0] {HALTED, STEP, RUNNING, BREAK} run_state_t`. It is shared with the display wrapper.
- One sub-module, `sync_edge_detect` (parameter `SYNC_STAGES`; ports `clk`, `reset_n`, `in`, `pulse`), is instantiated three times.

## Test plan
- Reset: assert `reset_n`=0 mid-RUNNING with `retired`=0x25 → `hart_en`=0 in the same cycle; after release `state`=HALTED and `retired`=0.
- Single step: from HALTED, pulse `step_req` high for 5 cycles → exactly one cycle of `hart_en`=1 at edge k+3 (SYNC_STAGES=2), then `retired`=1 and `state`=HALTED.
- Breakpoint: `bp_enable`=1, `bp_addr`=0x10, run with `pc` advancing by 4 per enabled cycle from 0 → `hart_en` is low in the cycle where `pc`=0x10, `state`=BREAK, `retired`=4.
- Resume past breakpoint: from the BREAK state above, pulse `run_req` → first cycle has `hart_en`=1 at `pc`=0x10, `pc` reaches 0x14, and the run continues without re-breaking.
- Priority: same-cycle rising edges on `halt_req` and `run_req` from HALTED → stays in HALTED; during RUNNING, `halt_req` alone → HALTED and `hart_en`=0 after 3 edges.
- Wrap: force `retired`=0xFFFF_FFFF, then run 1 cycle → `retired`=0.
